multi_interval_timer: RTL and testbench

MULTI_INTERVAL_TIMER -- requirements
Module: multi_interval_timer

---
 rtl/multi_interval_timer.sv | 164 ++++++++++++++++
 tb/tb_multi_interval_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_interval_timer.sv
// multi_interval_timer: NUM_CH independent down-counting interval timers behind an Avalon-style slave.
// Define TIMER_SNAPSHOT_EN to build the per-channel SNAP capture register; otherwise SNAP reads 0.
module multi_interval_timer #(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  localparam int         AW             = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam logic [CNT_W-1:0] DEF_P = DEFAULT_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [NUM_CH-1:0] to_q, to_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] ito_q, ito_d;
  logic [NUM_CH-1:0] cont_q, cont_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef TIMER_SNAPSHOT_EN
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_d   [NUM_CH];
`endif

  logic [AW-1:0]     addr_ch;
  logic [1:0]        reg_sel;
  logic              wr_en;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] stop_wr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] zero_hit;

  assign addr_ch = address >> 2;
  assign reg_sel = address[1:0];
  assign wr_en   = chipselect & ~write_n;

  // Out-of-range channel indices match no channel, so they are never written and read as 0.
  always_comb begin
    ch_sel   = '0;
    ch_wr    = '0;
    stop_wr  = '0;
    tick     = '0;
    zero_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c]   = (addr_ch == AW'(c));
      ch_wr[c]    = wr_en & ch_sel[c];
      stop_wr[c]  = ch_wr[c] && (reg_sel == REG_CONTROL) && writedata[3];
      tick[c]     = run_q[c] & ~stop_wr[c];
      zero_hit[c] = tick[c] && (cnt_q[c] == '0);
    end
  end

  always_comb begin
    to_d   = to_q;
    run_d  = run_q;
    ito_d  = ito_q;
    cont_d = cont_q;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]    = cnt_q[c];
      period_d[c] = period_q[c];
`ifdef TIMER_SNAPSHOT_EN
      snap_d[c]   = snap_q[c];
`endif

      if (zero_hit[c]) begin
        cnt_d[c] = period_q[c];
        if (!cont_q[c]) run_d[c] = 1'b0;
      end else if (tick[c]) begin
        cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end

      // The clear is applied first so a simultaneous timeout leaves TO set.
      if (ch_wr[c] && (reg_sel == REG_STATUS)) to_d[c] = 1'b0;
      if (zero_hit[c]) to_d[c] = 1'b1;

      if (ch_wr[c] && (reg_sel == REG_CONTROL)) begin
        ito_d[c]  = writedata[0];
        cont_d[c] = writedata[1];
        if (writedata[3])      run_d[c] = 1'b0;
        else if (writedata[2]) run_d[c] = 1'b1;
      end

      if (ch_wr[c] && (reg_sel == REG_PERIOD)) begin
        period_d[c] = writedata[CNT_W-1:0];
        cnt_d[c]    = writedata[CNT_W-1:0];
      end

`ifdef TIMER_SNAPSHOT_EN
      if (ch_wr[c] && (reg_sel == REG_SNAP)) snap_d[c] = cnt_q[c];
`endif
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          REG_STATUS:  rdata_d = {30'd0, run_q[c], to_q[c]};
          REG_CONTROL: rdata_d = {30'd0, cont_q[c], ito_q[c]};
          REG_PERIOD:  rdata_d = 32'(period_q[c]);
`ifdef TIMER_SNAPSHOT_EN
          REG_SNAP:    rdata_d = 32'(snap_q[c]);
`else
          REG_SNAP:    rdata_d = '0;
`endif
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= DEF_P;
        period_q[c] <= DEF_P;
`ifdef TIMER_SNAPSHOT_EN
        snap_q[c]   <= '0;
`endif
      end
      to_q    <= '0;
      run_q   <= '0;
      ito_q   <= '0;
      cont_q  <= '0;
      rdata_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        period_q[c] <= period_d[c];
`ifdef TIMER_SNAPSHOT_EN
        snap_q[c]   <= snap_d[c];
`endif
      end
      to_q    <= to_d;
      run_q   <= run_d;
      ito_q   <= ito_d;
      cont_q  <= cont_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq_vec  = to_q & ito_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed self-checking bench for multi_interval_timer (3 channels, 16-bit counters, short default period).
module tb_multi_interval_timer;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(NUM_CH) + 2;
`ifdef TIMER_SNAPSHOT_EN
  localparam logic [31:0] SNAP_EXP = 32'd70;
`else
  localparam logic [31:0] SNAP_EXP = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  multi_interval_timer #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_PERIOD(32'd7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic bus_write(input int addr, input logic [31:0] data);
    address    = AW'(addr);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int addr, output logic [31:0] data);
    address = AW'(addr);
    @(negedge clk);
    data = readdata;
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    bus_read(2, rd);  check("rst_period_ch0", rd, 32'd7);
    bus_read(0, rd);  check("rst_status_ch0", rd, 32'd0);
    bus_read(1, rd);  check("rst_control_ch0", rd, 32'd0);

    // ch0 continuous, period 4: timeout every 5 clocks
    bus_write(2, 32'd4);
    bus_write(1, 32'h7);
    repeat (4) @(negedge clk);
    check("cont_pre_to", 32'(irq), 32'd0);
    @(negedge clk);
    check("cont_first_to", 32'(irq), 32'd1);
    check("cont_irq_vec", 32'(irq_vec), 32'b001);
    bus_write(0, 32'd0);
    check("status_clear", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    check("cont_pre_to2", 32'(irq), 32'd0);
    @(negedge clk);
    check("cont_second_to", 32'(irq), 32'd1);
    bus_read(0, rd);  check("cont_status", rd, 32'd3);

    // STATUS write landing on the reload edge loses to the timeout
    bus_write(0, 32'd0);
    check("clear_before_coinc", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    bus_write(0, 32'd0);
    check("coinc_irq", 32'(irq), 32'd1);
    bus_read(0, rd);  check("coinc_status", rd, 32'd3);
    bus_write(1, 32'h8);
    bus_write(0, 32'd0);
    check("ch0_stopped_irq", 32'(irq), 32'd0);
    bus_read(0, rd);  check("ch0_stopped_status", rd, 32'd0);

    // ch1 one-shot, period 9
    bus_write(6, 32'd9);
    bus_write(5, 32'h5);
    repeat (9) @(negedge clk);
    check("oneshot_pre_to", 32'(irq_vec), 32'b000);
    @(negedge clk);
    check("oneshot_to", 32'(irq_vec), 32'b010);
    bus_read(4, rd);  check("oneshot_status", rd, 32'd1);
    bus_write(4, 32'd0);
    check("oneshot_clear", 32'(irq), 32'd0);
    bus_write(5, 32'h5);
    repeat (9) @(negedge clk);
    check("restart_pre_to", 32'(irq), 32'd0);
    @(negedge clk);
    check("restart_to", 32'(irq_vec), 32'b010);

    // START and STOP together while stopped
    bus_write(4, 32'd0);
    bus_write(5, 32'hD);
    bus_read(4, rd);  check("startstop_status", rd, 32'd0);
    bus_read(5, rd);  check("startstop_control", rd, 32'd1);
    bus_write(5, 32'h5);
    repeat (9) @(negedge clk);
    check("startstop_pre_to", 32'(irq), 32'd0);
    @(negedge clk);
    check("startstop_to", 32'(irq_vec), 32'b010);
    bus_write(4, 32'd0);

    // independence and out-of-range channel
    bus_write(14, 32'd5);
    bus_read(14, rd); check("bad_ch_period", rd, 32'd0);
    bus_read(12, rd); check("bad_ch_status", rd, 32'd0);
    bus_read(10, rd); check("ch2_period_untouched", rd, 32'd7);
    bus_read(2, rd);  check("ch0_period_kept", rd, 32'd4);
    bus_read(6, rd);  check("ch1_period_kept", rd, 32'd9);

    // snapshot 30 clocks after START with period 100
    bus_write(10, 32'd100);
    bus_write(9, 32'h6);
    repeat (30) @(negedge clk);
    bus_write(11, 32'd0);
    bus_read(11, rd); check("snap_value", rd, SNAP_EXP);

    // period 0 continuous: TO stays set despite clears
    bus_write(10, 32'd0);
    bus_write(8, 32'd0);
    bus_read(8, rd);  check("period0_status", rd, 32'd3);
    bus_write(8, 32'd0);
    bus_read(8, rd);  check("period0_status2", rd, 32'd3);
    bus_write(9, 32'h8);

    // reset mid-count with a concurrent bus write
    bus_write(1, 32'h7);
    repeat (5) @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'd1);
    reset      = 1'b1;
    address    = AW'(6);
    writedata  = 32'd3;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("mid_reset_irq", 32'(irq), 32'd0);
    check("mid_reset_irq_vec", 32'(irq_vec), 32'd0);
    check("mid_reset_readdata", readdata, 32'd0);
    bus_read(6, rd);  check("mid_reset_ch1_period", rd, 32'd7);
    bus_read(2, rd);  check("mid_reset_ch0_period", rd, 32'd7);
    bus_read(0, rd);  check("mid_reset_ch0_status", rd, 32'd0);
    repeat (10) @(negedge clk);
    bus_write(1, 32'h5);
    repeat (7) @(negedge clk);
    check("post_reset_pre_to", 32'(irq), 32'd0);
    @(negedge clk);
    check("post_reset_to", 32'(irq_vec), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
